alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
- Sequential 16-bit ALU directly upstream of the Flags register.
- Accepts an operation on a start/busy handshake and executes it in one or more cycles.
- On completion, presents a registered result and the four ALU condition bits, and pulses flags_en for exactly one cycle so Flags latches them.
- Shifts run one bit per cycle. Multiply is an iterative shift-add.

Parameters:
WIDTH, 16, datapath width
SHAMT_BITS, 4, width of shift amount taken from b[SHAMT_BITS-1:0]
MUL_CYCLES, 16, iterations for multiply (equals WIDTH)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  request; accepted on an edge where start=1 and busy=0
op  in  4  opcode, sampled with start
a  in  WIDTH  operand A, sampled with start
b  in  WIDTH  operand B / shift amount, sampled with start
result  out  WIDTH  registered result, held until next completion
alu_zero  out  1  result==0
alu_negative  out  1  result[WIDTH-1]
alu_carry  out  1  carry/borrow/shift-out/mul-high (see below)
alu_overflow  out  1  signed overflow / mul-high
flags_en  out  1  one-cycle strobe to Flags on valid completion
busy  out  1  operation in progress; start ignored
done  out  1  one-cycle completion pulse, coincident with flags_en

Behaviour:
- Reset values: result=0, alu_zero=0, alu_negative=0, alu_carry=0, alu_overflow=0, flags_en=0, busy=0, done=0, FSM=IDLE.
- Reset mid-operation aborts the operation: no done, no flags_en, outputs cleared.
- FSM states:
  - IDLE: on accept, go to EXEC (multi-cycle op) or FINISH (single-cycle op).
  - EXEC: one iteration per cycle; go to FINISH when the counter expires.
  - FINISH: outputs update; done=flags_en=1 for one cycle; return to IDLE.
- Timing: accepting edge is k.
  - Single-cycle ops: outputs valid and done high after edge k+1.
  - Shift by n: done after edge k+1+n; n=0 behaves as single-cycle.
  - MUL: done after edge k+MUL_CYCLES.
- busy: high from after edge k through the cycle before done; low in the done cycle.
- start with done=1 is accepted (back-to-back). start while busy=1 is dropped, not queued.
- Operands and op are captured at accept; input changes during busy have no effect.
- Opcodes:
  - 0 ADD: {carry,result}=a+b; overflow = operand signs equal and differ from result sign.
  - 1 SUB: result=a-b; carry=1 iff a<b unsigned (borrow); overflow = operand signs differ and result sign differs from a.
  - 2 AND, 3 OR, 4 XOR, 5 NOT(a): carry=0, overflow=0.
  - 6 SHL, 7 SHR logical, 8 SAR arithmetic, by n=b[3:0]: carry = last bit shifted out (0 if n=0); overflow=0.
  - 9 MUL unsigned: result = low 16 bits of the product; carry = overflow = (high 16 bits != 0).
  - 10-15 reserved: complete in 1 cycle with done=1, flags_en=0, result and flags unchanged.
- zero and negative are always derived from the final 16-bit result.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_ADD..OP_MUL), FSM state encoding, WIDTH default.
- One sub-module, shift_add_multiplier: start/done iterative 16x16 multiplier returning the 32-bit product. The top level owns the FSM, the shifter and the flag logic.

Test Plan:
- ADD a=16'h7FFF b=16'h0001 -> after edge k+1: result=16'h8000, negative=1, overflow=1, carry=0, zero=0, flags_en pulse of 1 cycle.
- SUB a=16'h0003 b=16'h0003, then a=16'h0000 b=16'h0001 -> first: result=0, zero=1, carry=0; second: result=16'hFFFF, carry=1, negative=1, overflow=0.
- SHL a=16'h8001 b=4'd1 -> done at k+2, result=16'h0002, carry=1. SAR a=16'h8000 b=4'd15 -> done at k+16, result=16'hFFFF, carry=0. SHL with b=0 -> done at k+1, carry=0.
- MUL a=16'h0100 b=16'h0100 -> done at k+16, result=0, zero=1, carry=1, overflow=1. MUL 3*5 -> result=16'h000F, carry=0.
- start re-asserted with new operands while busy during a MUL -> ignored, original result returned. start held high in the done cycle -> next op accepted, busy high the following cycle.
- reset=1 at k+5 of a MUL -> after that edge all outputs 0, no flags_en. Reserved op 4'hF -> done=1, flags_en=0, previous result unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the multi-cycle ALU: default sizes, opcodes, FSM encoding.
package alu_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_SHAMT_BITS = 4;
  localparam int DEF_MUL_CYCLES = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SAR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXEC   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier. The first partial product is taken on the
// start edge; done is high during the cycle of the final iteration, so product is
// complete immediately after that edge.
module shift_add_multiplier #(
  parameter int WIDTH = 16,
  parameter int ITERS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(ITERS);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               active;

  assign done = active && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      active  <= 1'b0;
    end else if (start) begin
      product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand   <= {{WIDTH{1'b0}}, a} << 1;
      mplier  <= b >> 1;
      cnt     <= CW'(ITERS - 2);
      active  <= 1'b1;
    end else if (active) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Sequential ALU feeding the Flags register: start/busy handshake, bit-serial shifts,
// iterative multiply, registered result and condition bits with a one-cycle flags_en.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SHAMT_BITS = DEF_SHAMT_BITS,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             alu_zero,
  output logic             alu_negative,
  output logic             alu_carry,
  output logic             alu_overflow,
  output logic             flags_en,
  output logic             busy,
  output logic             done
);

  logic [1:0]            state;
  logic [3:0]            op_r;
  logic [WIDTH-1:0]      a_r, b_r, sh_r;
  logic                  sh_c;
  logic [SHAMT_BITS-1:0] cnt;
  logic [SHAMT_BITS-1:0] shamt;
  logic                  accept;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    product;
  logic [WIDTH:0]        sum;
  logic [WIDTH-1:0]      res_n;
  logic                  c_n, v_n, wr_n;

  assign busy   = (state != ST_IDLE);
  assign accept = start && !busy;
  assign shamt  = b[SHAMT_BITS-1:0];
  assign sum    = {1'b0, a_r} + {1'b0, b_r};

  // The multiplier latches its own operands on the accepting edge.
  shift_add_multiplier #(.WIDTH(WIDTH), .ITERS(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && (op == OP_MUL)),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    res_n = result;
    c_n   = 1'b0;
    v_n   = 1'b0;
    wr_n  = 1'b1;
    case (op_r)
      OP_ADD: begin
        res_n = sum[WIDTH-1:0];
        c_n   = sum[WIDTH];
        v_n   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_n[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        res_n = a_r - b_r;
        c_n   = (a_r < b_r);
        v_n   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (res_n[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_AND: res_n = a_r & b_r;
      OP_OR:  res_n = a_r | b_r;
      OP_XOR: res_n = a_r ^ b_r;
      OP_NOT: res_n = ~a_r;
      OP_SHL, OP_SHR, OP_SAR: begin
        res_n = sh_r;
        c_n   = sh_c;
      end
      OP_MUL: begin
        res_n = product[WIDTH-1:0];
        c_n   = |product[2*WIDTH-1:WIDTH];
        v_n   = c_n;
      end
      default: wr_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_r         <= '0;
      a_r          <= '0;
      b_r          <= '0;
      sh_r         <= '0;
      sh_c         <= 1'b0;
      cnt          <= '0;
      result       <= '0;
      alu_zero     <= 1'b0;
      alu_negative <= 1'b0;
      alu_carry    <= 1'b0;
      alu_overflow <= 1'b0;
      flags_en     <= 1'b0;
      done         <= 1'b0;
    end else begin
      done     <= 1'b0;
      flags_en <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          op_r <= op;
          a_r  <= a;
          b_r  <= b;
          sh_r <= a;
          sh_c <= 1'b0;
          cnt  <= shamt;
          if (op == OP_MUL || (is_shift(op) && shamt != '0)) state <= ST_EXEC;
          else                                              state <= ST_FINISH;
        end
        ST_EXEC: begin
          if (op_r == OP_MUL) begin
            if (mul_done) state <= ST_FINISH;
          end else begin
            case (op_r)
              OP_SHL:  begin sh_r <= {sh_r[WIDTH-2:0], 1'b0};          sh_c <= sh_r[WIDTH-1]; end
              OP_SHR:  begin sh_r <= {1'b0, sh_r[WIDTH-1:1]};          sh_c <= sh_r[0];       end
              default: begin sh_r <= {sh_r[WIDTH-1], sh_r[WIDTH-1:1]}; sh_c <= sh_r[0];       end
            endcase
            cnt <= cnt - 1'b1;
            if (cnt == SHAMT_BITS'(1)) state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          done  <= 1'b1;
          // Reserved opcodes complete without touching the result or the Flags register.
          if (wr_n) begin
            result       <= res_n;
            alu_zero     <= (res_n == '0);
            alu_negative <= res_n[WIDTH-1];
            alu_carry    <= c_n;
            alu_overflow <= v_n;
            flags_en     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
